// File: rtl/lcd_timed_bus_ctrl_if.sv
// Avalon-MM slave-side bus bundle for the character-LCD controller.
interface lcd_timed_bus_ctrl_if;
    logic [1:0] address;
    logic       read;
    logic       write;
    logic [7:0] writedata;
    logic [7:0] readdata;
    logic       waitrequest;

    modport master (output address, read, write, writedata, input readdata, waitrequest);
    modport slave  (input address, read, write, writedata, output readdata, waitrequest);
endinterface

// File: rtl/lcd_timed_bus_ctrl.sv
// HD44780-class LCD bus controller: counter-timed E strobe, optional 4-bit nibble
// transfers and automatic busy-flag polling; the Avalon master is stalled for the whole cycle.
module lcd_timed_bus_ctrl #(
    parameter int SETUP_CYCLES  = 2,
    parameter int E_HIGH_CYCLES = 12,
    parameter int HOLD_CYCLES   = 2,
    parameter int GAP_CYCLES    = 20,
    parameter int BUS_WIDTH     = 8,
    parameter int BUSY_POLL     = 0,
    parameter int POLL_LIMIT    = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    lcd_timed_bus_ctrl_if.slave  avs,
    output logic                 LCD_E,
    output logic                 LCD_RS,
    output logic                 LCD_RW,
    output logic [7:0]           LCD_data_out,
    output logic                 LCD_data_oe,
    input  logic [7:0]           LCD_data_in,
    output logic                 poll_timeout
);
    localparam int M1   = (SETUP_CYCLES > E_HIGH_CYCLES) ? SETUP_CYCLES : E_HIGH_CYCLES;
    localparam int M2   = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int MAXP = (M1 > M2) ? M1 : M2;
    localparam int CW   = $clog2(MAXP + 1);
    localparam int PW   = $clog2(POLL_LIMIT + 1);

    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] EHIGH_LAST = CW'(E_HIGH_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
    localparam logic [PW-1:0] POLL_MAX   = PW'(POLL_LIMIT);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] EHIGH = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] GAP   = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] poll_cnt_q, poll_cnt_d;
    logic          nib_q, nib_d;
    logic          polling_q, polling_d;
    logic          db7_q, db7_d;
    logic          rs_q, rs_d, rw_q, rw_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    rdata_q, rdata_d;
    logic [7:0]    dout_q, dout_d;
    logic          e_q, oe_q, timeout_q, timeout_d;
    logic          start;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CW'(1);
        poll_cnt_d = poll_cnt_q;
        nib_d      = nib_q;
        polling_d  = polling_q;
        db7_d      = db7_q;
        rs_d       = rs_q;
        rw_d       = rw_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        dout_d     = dout_q;
        timeout_d  = timeout_q;
        start      = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (avs.read || avs.write) begin
                    rs_d       = avs.address[1];
                    rw_d       = avs.address[0] | avs.read;
                    wdata_d    = avs.writedata;
                    timeout_d  = 1'b0;
                    nib_d      = 1'b0;
                    polling_d  = 1'b0;
                    poll_cnt_d = '0;
                    start      = 1'b1;
                    state_d    = SETUP;
                end
            end
            SETUP: if (cnt_q == SETUP_LAST) begin cnt_d = '0; state_d = EHIGH; end
            EHIGH: if (cnt_q == EHIGH_LAST) begin
                cnt_d   = '0;
                state_d = HOLD;
                // Busy flag always lives on DB7, i.e. the first nibble in 4-bit mode.
                if (rw_q && polling_q) begin
                    if (!nib_q) db7_d = LCD_data_in[7];
                end else if (rw_q) begin
                    if (BUS_WIDTH == 4) begin
                        if (nib_q) rdata_d[3:0] = LCD_data_in[7:4];
                        else       rdata_d[7:4] = LCD_data_in[7:4];
                    end else begin
                        rdata_d = LCD_data_in;
                    end
                end
            end
            HOLD: if (cnt_q == HOLD_LAST) begin cnt_d = '0; state_d = GAP; end
            GAP: if (cnt_q == GAP_LAST) begin
                cnt_d = '0;
                if (BUS_WIDTH == 4 && !nib_q) begin
                    nib_d   = 1'b1;
                    start   = 1'b1;
                    state_d = SETUP;
                end else if (BUSY_POLL != 0 && (polling_q ? db7_q : !rw_q)) begin
                    if (poll_cnt_q < POLL_MAX) begin
                        poll_cnt_d = poll_cnt_q + PW'(1);
                        polling_d  = 1'b1;
                        rs_d       = 1'b0;
                        rw_d       = 1'b1;
                        nib_d      = 1'b0;
                        start      = 1'b1;
                        state_d    = SETUP;
                    end else begin
                        timeout_d = 1'b1;
                        state_d   = DONE;
                    end
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin cnt_d = '0; state_d = IDLE; end
            default: begin cnt_d = '0; state_d = IDLE; end
        endcase
        if (start)
            dout_d = rw_d ? 8'h00 :
                     (BUS_WIDTH == 4) ? {(nib_d ? wdata_d[3:0] : wdata_d[7:4]), 4'h0} : wdata_d;
    end

    // Pin registers are loaded from next state so pins change on the state's first cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            poll_cnt_q <= '0;
            nib_q      <= 1'b0;
            polling_q  <= 1'b0;
            db7_q      <= 1'b0;
            rs_q       <= 1'b0;
            rw_q       <= 1'b1;
            wdata_q    <= '0;
            rdata_q    <= '0;
            dout_q     <= '0;
            e_q        <= 1'b0;
            oe_q       <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            poll_cnt_q <= poll_cnt_d;
            nib_q      <= nib_d;
            polling_q  <= polling_d;
            db7_q      <= db7_d;
            rs_q       <= rs_d;
            rw_q       <= rw_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            dout_q     <= dout_d;
            e_q        <= (state_d == EHIGH);
            oe_q       <= !rw_d && (state_d == SETUP || state_d == EHIGH || state_d == HOLD);
            timeout_q  <= timeout_d;
        end
    end

    assign LCD_E           = e_q;
    assign LCD_RS          = rs_q;
    assign LCD_RW          = rw_q;
    assign LCD_data_out    = dout_q;
    assign LCD_data_oe     = oe_q;
    assign poll_timeout    = timeout_q;
    assign avs.readdata    = rdata_q;
    assign avs.waitrequest = reset || ((avs.read || avs.write) && state_q != DONE);
endmodule
